// File: rtl/stall_ctrl.sv
// Decides whether the D-stage instruction may advance. It also tracks how long the multiply/divide unit
// stays busy, and counts stalled cycles in a saturating counter.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_waddr,
  input  logic [4:0]       m_waddr,
  input  logic [1:0]       e_tnew,
  input  logic [1:0]       m_tnew,
  input  logic             md_start,
  input  logic             md_div,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_clr,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0]       MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0]       DIV_LOAD  = 4'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [4:0]       src  [2];
  logic [1:0]       tuse [2];
  logic [1:0]       hazard;
  logic             stall;
  logic [3:0]       cnt_q, cnt_d;
  logic             md_err_q, md_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign src[0]  = d_rs;
  assign src[1]  = d_rt;
  assign tuse[0] = d_tuse_rs;
  assign tuse[1] = d_tuse_rt;

  // Register 0 is never a real dependency, so excluding it on the source side covers waddr==0 too.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_haz
      assign hazard[gi] = (src[gi] != 5'd0) &&
                          (((src[gi] == e_waddr) && (e_tnew > tuse[gi])) ||
                           ((src[gi] == m_waddr) && (m_tnew > tuse[gi])));
    end
  endgenerate

  assign md_busy   = md_start | (cnt_q != 4'd0);
  assign stall     = (|hazard) | (d_is_md & md_busy);
  assign pc_en     = ~stall;
  assign fd_en     = ~stall;
  assign de_clr    = stall;
  assign md_err    = md_err_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    cnt_d       = cnt_q;
    md_err_d    = md_err_q;
    stall_cnt_d = stall_cnt_q;
    // A start that arrives while busy is dropped; the timer keeps running.
    if (md_start && (cnt_q == 4'd0)) begin
      cnt_d = md_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (md_start && (cnt_q != 4'd0)) begin
      md_err_d = 1'b1;
    end
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl. Directed scenarios and random traffic are checked against a cycle-level
// reference model that keeps the MDU busy window as a "busy until cycle" number.
module tb_stall_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    d_rs, d_rt, e_waddr, m_waddr;
  logic [1:0]    d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic          d_is_md, md_start, md_div;
  logic          pc_en, fd_en, de_clr, md_busy, md_err;
  logic [CW-1:0] stall_cnt;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_waddr(e_waddr), .m_waddr(m_waddr), .e_tnew(e_tnew), .m_tnew(m_tnew),
    .md_start(md_start), .md_div(md_div), .pc_en(pc_en), .fd_en(fd_en),
    .de_clr(de_clr), .md_busy(md_busy), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, start, div, is_md;
    logic [4:0] rs, rt, ew, mw;
    logic [1:0] urs, urt, en, mn;
  } stim_t;

  typedef struct {
    int tag;
    bit stall, busy, err;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: current cycle index, first cycle the MDU is free, sticky error, stall count.
  int   cyc = 0;
  int   busy_end = 0;
  bit   err_m = 0;
  int   scnt = 0;

  function automatic bit hz(input int src, input int tuse, input stim_t s);
    if (src == 0) return 1'b0;
    return ((src == int'(s.ew)) && (int'(s.en) > tuse)) ||
           ((src == int'(s.mw)) && (int'(s.mn) > tuse));
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.urs = 2'd3;
    s.urt = 2'd3;
    return s;
  endfunction

  task automatic chk(input string name, input int tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, tag, got, want);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit   busy;
    reset = s.rst; md_start = s.start; md_div = s.div; d_is_md = s.is_md;
    d_rs = s.rs; d_rt = s.rt; e_waddr = s.ew; m_waddr = s.mw;
    d_tuse_rs = s.urs; d_tuse_rt = s.urt; e_tnew = s.en; m_tnew = s.mn;
    busy    = s.start || (cyc < busy_end);
    e.tag   = cyc;
    e.busy  = busy;
    e.stall = hz(int'(s.rs), int'(s.urs), s) || hz(int'(s.rt), int'(s.urt), s) || (s.is_md && busy);
    e.err   = err_m;
    e.cnt   = scnt;
    sb.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      busy_end = 0; err_m = 0; scnt = 0;
    end else begin
      if (s.start && (cyc >= busy_end)) busy_end = cyc + (s.div ? 10 : 5);
      else if (s.start) err_m = 1;
      if (e.stall && scnt < 15) scnt++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pc_en",     e.tag, int'(pc_en),     int'(!e.stall));
        chk("fd_en",     e.tag, int'(fd_en),     int'(!e.stall));
        chk("de_clr",    e.tag, int'(de_clr),    int'(e.stall));
        chk("md_busy",   e.tag, int'(md_busy),   int'(e.busy));
        chk("md_err",    e.tag, int'(md_err),    int'(e.err));
        chk("stall_cnt", e.tag, int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    reset = 1'b1; md_start = 0; md_div = 0; d_is_md = 0;
    d_rs = 0; d_rt = 0; e_waddr = 0; m_waddr = 0;
    d_tuse_rs = 3; d_tuse_rt = 3; e_tnew = 0; m_tnew = 0;
    repeat (2) @(posedge clk);
    #1;
    s = idle(); s.rst = 1; step(s);
    step(idle());

    // Load-use: E result two cycles out, needed in one.
    s = idle(); s.ew = 8; s.en = 2; s.rs = 8; s.urs = 1; step(s);
    s.en = 1; step(s);
    step(idle());
    // No false hazards.
    s = idle(); s.rs = 0; s.ew = 0; s.en = 2; step(s);
    s = idle(); s.rt = 9; s.mw = 9; s.mn = 1; s.urt = 3; step(s);
    s = idle(); s.rt = 9; s.mw = 9; s.mn = 1; s.urt = 0; step(s);
    s = idle(); s.rs = 4; s.rt = 4; s.ew = 4; s.mw = 4; s.en = 2; s.mn = 1; s.urs = 0; s.urt = 0; step(s);

    // Multiply, then mflo held in D.
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.is_md = 1; s.start = 1; s.div = 0; step(s);
    s.start = 0;
    for (int i = 0; i < 6; i++) step(s);

    // Divide, with a second start attempt in cycle 3.
    s = idle(); s.start = 1; s.div = 1; step(s);
    for (int i = 1; i < 12; i++) begin
      s = idle(); s.start = (i == 3); step(s);
    end
    // Back-to-back multiplies once the first one finishes.
    s = idle(); s.start = 1; step(s);
    for (int i = 1; i < 5; i++) step(idle());
    s = idle(); s.start = 1; step(s);
    step(idle());

    // Reset in cycle 4 of a divide.
    s = idle(); s.start = 1; s.div = 1; s.is_md = 1; step(s);
    s.start = 0;
    for (int i = 1; i < 4; i++) step(s);
    s = idle(); s.rst = 1; s.is_md = 1; s.start = 1; step(s);
    s = idle(); s.is_md = 1; step(s);
    step(s);

    // Counter saturation.
    s = idle(); s.ew = 3; s.en = 2; s.rt = 3; s.urt = 0;
    for (int i = 0; i < 20; i++) step(s);
    step(idle());

    // Random traffic over a small register range, so that hazards and MDU overlaps happen often.
    for (int i = 0; i < 800; i++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      s.start = ($urandom_range(0, 5) == 0);
      s.div   = 1'($urandom_range(0, 1));
      s.is_md = ($urandom_range(0, 2) == 0);
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.ew    = 5'($urandom_range(0, 3));
      s.mw    = 5'($urandom_range(0, 3));
      s.urs   = 2'($urandom_range(0, 3));
      s.urt   = 2'($urandom_range(0, 3));
      s.en    = 2'($urandom_range(0, 2));
      s.mn    = 2'($urandom_range(0, 1));
      step(s);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", cyc, sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall controller for the five-stage MIPS core. Each cycle it decides whether the instruction in D may advance. When it may not, it drives the enables and synchronous clears of the F/D and D/E level registers: PC and F/D hold, and D/E loads a bubble. It combines register-use hazard detection (Tuse/Tnew) with an internal busy timer for the multi-cycle multiply/divide unit, and keeps a saturating stall-cycle counter for performance checks.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu, counted from the start cycle inclusive (1..16)
- DIV_CYCLES, 10, busy duration of div/divu, counted from the start cycle inclusive (1..16)
- CNT_W, 32, stall counter width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- d_rs, d_rt  in  5 each  source register numbers of the D-stage instruction
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until the operand is needed; 3 = operand not used
- d_is_md  in  1  D instruction touches HI/LO or the MDU (mult/div/mf*/mt*)
- e_waddr, m_waddr  in  5 each  destination register of the E and M instructions; 0 = none
- e_tnew  in  2  cycles until the E result is ready (0..2)
- m_tnew  in  2  cycles until the M result is ready (0..1)
- md_start  in  1  E stage launches mult/multu/div/divu this cycle
- md_div  in  1  with md_start: 1 = divide, 0 = multiply
- pc_en, fd_en  out  1  enables of the PC and the F/D level register
- de_clr  out  1  synchronous clear (bubble) for the D/E level register
- md_busy  out  1  MDU occupied
- md_err  out  1  sticky: md_start seen while the MDU was busy
- stall_cnt  out  CNT_W  number of stalled cycles since reset

## Operation
- rs hazard = d_rs≠0 and one of these holds:
  - d_rs==e_waddr and e_tnew>d_tuse_rs
  - d_rs==m_waddr and m_tnew>d_tuse_rs
- rt hazard: same as rs hazard, using d_rt and d_tuse_rt.
- A match in both E and M still raises only one hazard.
- waddr 0 never matches, because d_rs/d_rt of 0 is excluded.
- Busy timer `cnt` (4 bits):
  - On md_start while cnt==0, load (md_div ? DIV_CYCLES : MULT_CYCLES)−1.
  - Otherwise, while cnt≠0, decrement by 1 per cycle, stopping at 0.
- md_busy = md_start | (cnt≠0). This is combinational.
- If md_start arrives while cnt≠0:
  - The start is ignored and cnt keeps counting down.
  - md_err sets and stays 1 until reset.
- stall = rs hazard | rt hazard | (d_is_md & md_busy).
- pc_en = fd_en = ~stall; de_clr = stall. E/M and M/W are never stalled by this block.
- stall_cnt increments on every clock where stall=1 and reset=0, and saturates at all-ones.
- Reset clears cnt, md_err and stall_cnt.
- Outputs are combinational from state and current inputs and are not gated by reset. With cnt=0 and no hazard inputs during reset: pc_en=1, fd_en=1, de_clr=0, md_busy=0.
- Reset mid-division: cnt=0 on the next cycle, so md_busy drops immediately.

## Timing
- Hazard outputs are same-cycle combinational, with no register stage; they must settle before the next clk edge.
- Multiply started at edge t (md_start high in cycle t):
  - md_busy is high in cycles t..t+MULT_CYCLES−1, i.e. 5 cycles by default.
  - md_busy is low at t+5.
- Divide: md_busy is high for 10 cycles, t..t+9.
- An mfhi in D during cycle t+4 stalls. The same instruction in D at t+5 advances.
- A new md_start is accepted in the first cycle where cnt==0. Back-to-back mult is therefore possible once busy drops.
- Stall and MDU wait together: stall stays high until both causes clear.
- stall_cnt changes at the edge that ends a stalled cycle; the update is visible the cycle after.

## Test plan
- Load-use: e_waddr=8, e_tnew=2, d_rs=8, d_tuse_rs=1 → stall=1, pc_en=0, de_clr=1, stall_cnt +1. Next cycle e_tnew=1 → stall=0.
- No false hazard:
  - d_rs=0 with e_waddr=0, e_tnew=2 → stall=0.
  - d_tuse_rt=3 with d_rt==m_waddr, m_tnew=1 → stall=0.
- Multiply then mflo: md_start=1, md_div=0 at cycle 0, d_is_md=1 held → stall=1 in cycles 0–4, 0 in cycle 5. stall_cnt=5.
- Divide with a second start at cycle 3 → md_err=1 and stays high. md_busy still drops at cycle 10; the second start does not extend it.
- Reset at cycle 4 of a divide → cycle 5: md_busy=0, md_err=0, stall_cnt=0, pc_en=1.
- Saturation with CNT_W=4: hold stall for 20 cycles → stall_cnt=15 and stays 15.
